cpu_hazard_ctrl: RTL and testbench
==================================

# cpu_hazard_ctrl

- Pipeline hazard controller paired with the forwarding unit.
- Keeps a per-register scoreboard of in-flight long-latency results (loads).
- Stalls IF/ID and injects an EX bubble when a decode-stage source reads a register whose value cannot yet be bypassed.
- Sequences data-cache-miss stalls and multi-cycle front-end flushes, and reports its state.

## Interface

Parameters:
- NUM_REGS, default `NUM_REGS: architectural register count; index width RW = $clog2(NUM_REGS).
- R0_ZERO, default 1: register 0 is hardwired; it is never marked busy and never causes a hazard.
- FLUSH_CYCLES, default 2: number of cycles id_kill stays high per flush; must be ≥1.

Ports:
- clk in 1: single clock; all state updates on the rising edge.
- reset in 1: synchronous, active-high.
- id_valid in 1: decode holds a valid instruction.
- ra_id, rb_id in RW: decode source registers.
- ra_used, rb_used in 1: the corresponding source is actually read.
- issue_valid in 1: an instruction leaves decode into EX this cycle.
- issue_rd in RW: destination of the issuing instruction.
- issue_long in 1: the issuing instruction writes issue_rd through the writeback (long-latency) path.
- rd_wb in RW: writeback-stage destination.
- writeback_wb in 1: writeback-stage register write this cycle.
- mem_busy in 1: data memory cannot accept or complete an access.
- flush in 1: redirect from commit; squashes the IF/ID contents.
- stall_if out 1: hold PC and IF/ID.
- stall_id out 1: hold decode.
- bubble_ex out 1: insert a NOP into EX.
- id_kill out 1: invalidate IF/ID.
- state out 2: 0 RUN, 1 HAZARD, 2 MEM, 3 FLUSH.
- busy_vec out NUM_REGS: scoreboard bits.

## Operation

- Scoreboard busy_vec:
  - Set bit issue_rd on the edge where issue_valid & issue_long & ~stall_id, unless R0_ZERO and issue_rd==0.
  - Clear bit rd_wb on the edge where writeback_wb.
  - Same register set and cleared on the same edge: set wins, because the new producer is younger.
- Hazard (combinational):
  - haz = id_valid & ((ra_used & busy[ra_id] & ~(writeback_wb & rd_wb==ra_id)) | (the same term for rb)).
  - A writeback match is bypassed by the forwarding unit, so it does not stall.
- Output priority (combinational from inputs and registered state): FLUSH > MEM > HAZARD > RUN.
  - FLUSH active (flush input high, or flush counter nonzero): id_kill=1; stall_if=stall_id=bubble_ex=0.
  - mem_busy: stall_if=stall_id=1, bubble_ex=0. EX and later stages are held by the memory stage itself.
  - haz: stall_if=stall_id=1, bubble_ex=1.
  - Otherwise all outputs are 0.
- FSM, registered, next state by the same priority:
  - flush: enter FLUSH and load counter = FLUSH_CYCLES-1.
  - In FLUSH, the counter decrements each cycle; leave FLUSH at 0.
  - A flush arriving while in FLUSH reloads the counter.
  - mem_busy: MEM. haz: HAZARD. Otherwise RUN.
- Flush does not clear busy_vec; issued long ops always reach writeback.

## Timing

- Stall, bubble and kill outputs have 0-cycle latency from their inputs.
- busy_vec updates 1 cycle after issue or writeback.
- A load issued in cycle N with a dependent instruction in decode in cycle N+1:
  - Stall in N+1 and every later cycle until the writeback cycle.
  - In the writeback cycle the stall drops because the forwarding unit bypasses the value.
- A flush asserted in cycle N gives id_kill high for cycles N … N+FLUSH_CYCLES-1.
- Reset: on the edge where reset is high:
  - busy_vec=0, state=RUN (0), flush counter=0, perf counters=0.
  - While reset is high, stall_if/stall_id/bubble_ex/id_kill are forced to 0.
- Reset mid-stall or mid-flush: released on the next edge.

## Configuration

- CPU_HAZARD_PERF_EN defined:
  - Adds outputs hazard_cycles and mem_cycles, each 32 bits.
  - Each counts cycles in which that condition drove the stall outputs.
  - Counters saturate at 0xFFFFFFFF and are cleared by reset.
- Not defined: neither the ports nor the counters exist, and behaviour is otherwise identical.

## Test plan

- Load-use: issue a long op with rd=5 in cycle 0; decode ra_id=5, ra_used=1 from cycle 1; writeback_wb with rd_wb=5 in cycle 4.
  - Required: stall_if/stall_id/bubble_ex=1 in cycles 1–3 and 0 in cycle 4.
  - Required: busy_vec[5] is 1 from cycle 1 and 0 from cycle 5.
- R0 and unused sources:
  - Issue a long op with rd=0: busy_vec stays 0.
  - Busy r7 with rb_id=7 and rb_used=0: no stall.
- Simultaneous set/clear: writeback_wb with rd_wb=3 and a long issue with rd=3 in the same cycle → busy_vec[3]=1 afterwards.
- Priority: mem_busy=1 together with a hazard → stall_if=1, bubble_ex=0, state=MEM.
  - Then flush=1 → id_kill=1, stall_if=0, state=FLUSH for 2 cycles (FLUSH_CYCLES=2), with a reload if flush is re-asserted.
- Reset mid-operation: busy_vec=0x0000_00A0, state=FLUSH, reset for 1 cycle → busy_vec=0, state=RUN, all stall outputs 0.
- With CPU_HAZARD_PERF_EN: 3 hazard cycles plus 2 mem cycles → hazard_cycles=3, mem_cycles=2.
  - Preloaded at 0xFFFFFFFF, the counter holds its value.

Source files
------------

// File: rtl/cpu_hazard_ctrl_if.sv
// cpu_hazard_ctrl_if: decode/issue/writeback/memory/flush signals and stall outputs of the hazard controller
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

interface cpu_hazard_ctrl_if #(
    parameter int NUM_REGS = `NUM_REGS
);
    localparam int RW = $clog2(NUM_REGS);
    logic                id_valid;
    logic [RW-1:0]       ra_id;
    logic [RW-1:0]       rb_id;
    logic                ra_used;
    logic                rb_used;
    logic                issue_valid;
    logic [RW-1:0]       issue_rd;
    logic                issue_long;
    logic [RW-1:0]       rd_wb;
    logic                writeback_wb;
    logic                mem_busy;
    logic                flush;
    logic                stall_if;
    logic                stall_id;
    logic                bubble_ex;
    logic                id_kill;
    logic [1:0]          state;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output id_valid, ra_id, rb_id, ra_used, rb_used, issue_valid, issue_rd, issue_long,
               rd_wb, writeback_wb, mem_busy, flush,
        input  stall_if, stall_id, bubble_ex, id_kill, state, busy_vec
    );

    modport slave (
        input  id_valid, ra_id, rb_id, ra_used, rb_used, issue_valid, issue_rd, issue_long,
               rd_wb, writeback_wb, mem_busy, flush,
        output stall_if, stall_id, bubble_ex, id_kill, state, busy_vec
    );
endinterface

// File: rtl/cpu_hazard_ctrl.sv
// cpu_hazard_ctrl: load scoreboard, load-use stall/bubble, mem stall and multi-cycle flush sequencing.
// Define CPU_HAZARD_PERF_EN to add saturating hazard_cycles/mem_cycles counters.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

module cpu_hazard_ctrl #(
    parameter int NUM_REGS     = `NUM_REGS,
    parameter bit R0_ZERO      = 1'b1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    cpu_hazard_ctrl_if.slave  hif
`ifdef CPU_HAZARD_PERF_EN
    ,
    output logic [31:0]       hazard_cycles,
    output logic [31:0]       mem_cycles
`endif
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {RUN = 2'd0, HAZARD = 2'd1, MEM = 2'd2, FLUSH = 2'd3} state_t;

    state_t              state_q, state_n;
    logic [CW-1:0]       fcnt_q, fcnt_n;
    logic [NUM_REGS-1:0] busy_q, busy_n, set_vec, clr_vec;
    logic                ra_haz, rb_haz, haz, flush_act, do_set;

    // a source matching this cycle's writeback is bypassed, so it does not stall
    assign ra_haz    = hif.ra_used && busy_q[hif.ra_id] && !(hif.writeback_wb && hif.rd_wb == hif.ra_id);
    assign rb_haz    = hif.rb_used && busy_q[hif.rb_id] && !(hif.writeback_wb && hif.rd_wb == hif.rb_id);
    assign haz       = hif.id_valid && (ra_haz || rb_haz);
    assign flush_act = hif.flush || fcnt_q != '0;

    always_comb begin
        state_n = RUN;
        fcnt_n  = '0;
        state_n = flush_act ? FLUSH : hif.mem_busy ? MEM : haz ? HAZARD : RUN;
        fcnt_n  = hif.flush ? CW'(FLUSH_CYCLES - 1) : (fcnt_q != '0) ? fcnt_q - CW'(1) : '0;
    end

    assign hif.stall_if  = !reset && (state_n == MEM || state_n == HAZARD);
    assign hif.stall_id  = hif.stall_if;
    assign hif.bubble_ex = !reset && state_n == HAZARD;
    assign hif.id_kill   = !reset && state_n == FLUSH;
    assign hif.state     = state_q;
    assign hif.busy_vec  = busy_q;

    // set after clear: a younger producer of the same register keeps it busy
    assign do_set  = hif.issue_valid && hif.issue_long && !hif.stall_id && !(R0_ZERO && hif.issue_rd == '0);
    assign set_vec = do_set ? NUM_REGS'(1) << hif.issue_rd : '0;
    assign clr_vec = hif.writeback_wb ? NUM_REGS'(1) << hif.rd_wb : '0;
    assign busy_n  = (busy_q & ~clr_vec) | set_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_n;
            fcnt_q  <= fcnt_n;
            busy_q  <= busy_n;
        end
    end

`ifdef CPU_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hazard_cycles <= '0;
            mem_cycles    <= '0;
        end else begin
            if (state_n == HAZARD && hazard_cycles != '1) hazard_cycles <= hazard_cycles + 32'd1;
            if (state_n == MEM && mem_cycles != '1) mem_cycles <= mem_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// tb_cpu_hazard_ctrl: directed test-plan sequences plus randomized traffic against a behavioural scoreboard model
module tb_cpu_hazard_ctrl;
    localparam int NR = 32;
    localparam int FC = 2;
    localparam int RW = $clog2(NR);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_hazard_ctrl_if #(.NUM_REGS(NR)) hif();
`ifdef CPU_HAZARD_PERF_EN
    logic [31:0] hazard_cycles, mem_cycles;
`endif

    cpu_hazard_ctrl #(.NUM_REGS(NR), .R0_ZERO(1'b1), .FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .reset(reset),
        .hif(hif)
`ifdef CPU_HAZARD_PERF_EN
        ,
        .hazard_cycles(hazard_cycles),
        .mem_cycles(mem_cycles)
`endif
    );

    int npass = 0;
    int ntot = 0;
    int cyc_no = 0;
    int last_flush = -1000;
    bit mbusy[NR];
    int mstate = 0;
    logic [31:0] mhaz = 0;
    logic [31:0] mmem = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc_no, act, exp);
    endfunction

    function automatic bit src_haz(logic used, logic [RW-1:0] r);
        return used && mbusy[r] && !(hif.writeback_wb && hif.rd_wb == r);
    endfunction

    task automatic idle();
        hif.id_valid = 1'b0; hif.ra_id = '0; hif.rb_id = '0; hif.ra_used = 1'b0; hif.rb_used = 1'b0;
        hif.issue_valid = 1'b0; hif.issue_rd = '0; hif.issue_long = 1'b0;
        hif.rd_wb = '0; hif.writeback_wb = 1'b0; hif.mem_busy = 1'b0; hif.flush = 1'b0;
    endtask

    // compare DUT against the model for the current cycle, then advance the model across the edge
    task automatic cyc();
        bit haz, kill, stl;
        int cat;
        logic [NR-1:0] bv;
        #1;
        haz  = hif.id_valid && (src_haz(hif.ra_used, hif.ra_id) || src_haz(hif.rb_used, hif.rb_id));
        kill = hif.flush || (cyc_no - last_flush < FC);
        cat  = kill ? 3 : hif.mem_busy ? 2 : haz ? 1 : 0;
        stl  = !reset && (cat == 1 || cat == 2);
        for (int i = 0; i < NR; i++) bv[i] = mbusy[i];
        chk("stall_if", 32'(hif.stall_if), 32'(stl));
        chk("stall_id", 32'(hif.stall_id), 32'(stl));
        chk("bubble_ex", 32'(hif.bubble_ex), 32'(!reset && cat == 1));
        chk("id_kill", 32'(hif.id_kill), 32'(!reset && cat == 3));
        chk("state", 32'(hif.state), mstate);
        chk("busy_vec", hif.busy_vec, bv);
`ifdef CPU_HAZARD_PERF_EN
        chk("hazard_cycles", hazard_cycles, mhaz);
        chk("mem_cycles", mem_cycles, mmem);
`endif
        if (reset) begin
            for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
            mstate = 0; last_flush = -1000; mhaz = 0; mmem = 0;
        end else begin
            if (hif.writeback_wb) mbusy[hif.rd_wb] = 1'b0;
            if (hif.issue_valid && hif.issue_long && !stl && hif.issue_rd != '0) mbusy[hif.issue_rd] = 1'b1;
            if (hif.flush) last_flush = cyc_no;
            mstate = cat;
            if (cat == 1 && mhaz != 32'hFFFF_FFFF) mhaz++;
            if (cat == 2 && mmem != 32'hFFFF_FFFF) mmem++;
        end
        cyc_no++;
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_busy", hif.busy_vec, 0);
        chk("reset_state", 32'(hif.state), 0);
        cyc();
        reset = 1'b0;

        // load-use on r5
        hif.issue_valid = 1'b1; hif.issue_long = 1'b1; hif.issue_rd = 5'd5;
        cyc();
        idle(); hif.id_valid = 1'b1; hif.ra_id = 5'd5; hif.ra_used = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("lu_stall_if", 32'(hif.stall_if), 1);
            chk("lu_bubble", 32'(hif.bubble_ex), 1);
            chk("lu_busy5", 32'(hif.busy_vec[5]), 1);
            cyc();
        end
        hif.writeback_wb = 1'b1; hif.rd_wb = 5'd5;
        #1;
        chk("lu_wb_stall", 32'(hif.stall_id), 0);
        chk("lu_wb_bubble", 32'(hif.bubble_ex), 0);
        cyc();
        idle();
        #1;
        chk("lu_busy5_clr", 32'(hif.busy_vec[5]), 0);
        cyc();

        // r0 never busy; unused source ignored
        hif.issue_valid = 1'b1; hif.issue_long = 1'b1; hif.issue_rd = 5'd0;
        cyc();
        idle();
        #1;
        chk("r0_busy", hif.busy_vec, 0);
        hif.issue_valid = 1'b1; hif.issue_long = 1'b1; hif.issue_rd = 5'd7;
        cyc();
        idle(); hif.id_valid = 1'b1; hif.rb_id = 5'd7; hif.rb_used = 1'b0; hif.ra_used = 1'b1;
        #1;
        chk("unused_src_stall", 32'(hif.stall_if), 0);
        chk("r7_busy", 32'(hif.busy_vec[7]), 1);
        cyc();

        // simultaneous set and clear of r3
        idle(); hif.writeback_wb = 1'b1; hif.rd_wb = 5'd3;
        hif.issue_valid = 1'b1; hif.issue_long = 1'b1; hif.issue_rd = 5'd3;
        cyc();
        idle();
        #1;
        chk("setwins_busy3", 32'(hif.busy_vec[3]), 1);

        // priority: mem over hazard, flush over mem, flush reload
        hif.id_valid = 1'b1; hif.ra_id = 5'd3; hif.ra_used = 1'b1; hif.mem_busy = 1'b1;
        #1;
        chk("pri_mem_stall", 32'(hif.stall_if), 1);
        chk("pri_mem_bubble", 32'(hif.bubble_ex), 0);
        cyc();
        hif.flush = 1'b1;
        #1;
        chk("pri_mem_state", 32'(hif.state), 2);
        chk("pri_flush_kill", 32'(hif.id_kill), 1);
        chk("pri_flush_stall", 32'(hif.stall_if), 0);
        cyc();
        hif.flush = 1'b0;
        #1;
        chk("flush_kill2", 32'(hif.id_kill), 1);
        chk("flush_state1", 32'(hif.state), 3);
        cyc();
        #1;
        chk("flush_kill_end", 32'(hif.id_kill), 0);
        chk("flush_state2", 32'(hif.state), 3);
        cyc();
        hif.flush = 1'b1;
        cyc();
        cyc();
        hif.flush = 1'b0;
        #1;
        chk("reload_kill", 32'(hif.id_kill), 1);
        cyc();
        #1;
        chk("reload_kill_end", 32'(hif.id_kill), 0);
        chk("reload_state", 32'(hif.state), 3);
        cyc();

        // reset mid-flush with r5/r7 busy
        idle(); hif.writeback_wb = 1'b1; hif.rd_wb = 5'd3;
        hif.issue_valid = 1'b1; hif.issue_long = 1'b1; hif.issue_rd = 5'd5;
        cyc();
        idle(); hif.flush = 1'b1;
        cyc();
        idle();
        #1;
        chk("pre_reset_busy", hif.busy_vec, 32'h0000_00A0);
        chk("pre_reset_state", 32'(hif.state), 3);
        reset = 1'b1; hif.id_valid = 1'b1; hif.ra_id = 5'd5; hif.ra_used = 1'b1; hif.mem_busy = 1'b1;
        #1;
        chk("in_reset_stall", 32'(hif.stall_if), 0);
        chk("in_reset_kill", 32'(hif.id_kill), 0);
        cyc();
        reset = 1'b0; idle();
        #1;
        chk("post_reset_busy", hif.busy_vec, 0);
        chk("post_reset_state", 32'(hif.state), 0);
        chk("post_reset_kill", 32'(hif.id_kill), 0);
        cyc();

`ifdef CPU_HAZARD_PERF_EN
        hif.issue_valid = 1'b1; hif.issue_long = 1'b1; hif.issue_rd = 5'd9;
        cyc();
        idle(); hif.id_valid = 1'b1; hif.ra_id = 5'd9; hif.ra_used = 1'b1;
        repeat (3) cyc();
        idle(); hif.mem_busy = 1'b1;
        repeat (2) cyc();
        idle(); hif.writeback_wb = 1'b1; hif.rd_wb = 5'd9;
        #1;
        chk("perf_hazard", hazard_cycles, 3);
        chk("perf_mem", mem_cycles, 2);
        cyc();
`endif

        for (int n = 0; n < 4000; n++) begin
            reset            = ($urandom_range(0, 79) == 0);
            hif.id_valid     = 1'($urandom_range(0, 1));
            hif.ra_id        = RW'($urandom_range(0, 7));
            hif.rb_id        = RW'($urandom_range(0, 7));
            hif.ra_used      = 1'($urandom_range(0, 1));
            hif.rb_used      = 1'($urandom_range(0, 1));
            hif.issue_valid  = 1'($urandom_range(0, 1));
            hif.issue_long   = 1'($urandom_range(0, 1));
            hif.issue_rd     = RW'($urandom_range(0, 7));
            hif.writeback_wb = ($urandom_range(0, 2) == 0);
            hif.rd_wb        = RW'($urandom_range(0, 7));
            hif.mem_busy     = ($urandom_range(0, 5) == 0);
            hif.flush        = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
